// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master transaction controller, MSB first.
// Ports: req val/rdy/msg in, resp val/rdy/msg out, SPI pins, shreg controls.
module spi_master_ctrl #(
  parameter int nbits   = 8,
  parameter int clk_div = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [nbits-1:0] req_msg,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [nbits-1:0] resp_msg,
  output logic             spi_cs_n,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             shreg_load_en,
  output logic [nbits-1:0] shreg_load_data,
  output logic             shreg_shift_en,
  output logic             shreg_in,
  input  logic [nbits-1:0] shreg_out
);

  localparam int DW = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam int BW = $clog2(nbits + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(clk_div - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(nbits - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            miso_q, miso_d;
  logic            div_done;

  assign div_done        = (div_q == DIV_LAST);
  assign resp_msg        = shreg_out;
  assign spi_mosi        = shreg_out[nbits-1];
  assign shreg_load_data = req_msg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      miso_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      miso_q  <= miso_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    bit_d          = bit_q;
    miso_d         = miso_q;
    req_rdy        = 1'b0;
    resp_val       = 1'b0;
    spi_cs_n       = 1'b1;
    spi_sclk       = 1'b0;
    shreg_load_en  = 1'b0;
    shreg_shift_en = 1'b0;
    shreg_in       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // reset is async: keep rdy low while it is held
        req_rdy = reset;
        if (req_val && reset) begin
          shreg_load_en = 1'b1;
          div_d         = '0;
          bit_d         = '0;
          state_d       = S_SETUP;
        end
      end
      S_SETUP: begin
        spi_cs_n = 1'b0;
        if (div_done) begin
          div_d   = '0;
          miso_d  = spi_miso;
          state_d = S_HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HIGH: begin
        spi_cs_n = 1'b0;
        spi_sclk = 1'b1;
        if (div_done) begin
          // shift coincides with the SCLK falling edge
          shreg_shift_en = 1'b1;
          shreg_in       = miso_q;
          bit_d          = bit_q + 1'b1;
          div_d          = '0;
          state_d = (bit_q == BIT_LAST) ? S_HOLD : S_LOW;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_LOW: begin
        spi_cs_n = 1'b0;
        if (div_done) begin
          div_d   = '0;
          miso_d  = spi_miso;
          state_d = S_HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HOLD: begin
        spi_cs_n = 1'b0;
        if (div_done) begin
          div_d   = '0;
          state_d = S_RESP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_RESP: begin
        resp_val = 1'b1;
        if (resp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: randomized bench with a timeline model of the
// SPI master (nbits=8/clk_div=2) plus a small nbits=4/clk_div=1 instance.
module tb_spi_master_ctrl;
  localparam int N     = 8;
  localparam int D     = 2;
  localparam int CSLEN = D * (2 * N + 1);
  localparam int NB    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req_val = 0, req_rdy, resp_val, resp_rdy = 0;
  logic [N-1:0] req_msg = '0, resp_msg, ld_data;
  logic         cs_n, sclk, mosi, miso, ld_en, sh_en, sh_in;
  logic [N-1:0] shreg = '0;

  logic          b_req_val = 0, b_req_rdy, b_resp_val;
  logic          b_resp_rdy = 0;
  logic [NB-1:0] b_req_msg = '0, b_resp_msg, b_ld_data;
  logic          b_cs_n, b_sclk, b_mosi, b_ld_en, b_sh_en, b_sh_in;
  logic [NB-1:0] b_shreg = '0;

  spi_master_ctrl #(.nbits(N), .clk_div(D)) dut (
    .clk(clk), .reset(rst_n),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .spi_cs_n(cs_n), .spi_sclk(sclk), .spi_mosi(mosi),
    .spi_miso(miso), .shreg_load_en(ld_en),
    .shreg_load_data(ld_data), .shreg_shift_en(sh_en),
    .shreg_in(sh_in), .shreg_out(shreg)
  );

  spi_master_ctrl #(.nbits(NB), .clk_div(1)) dut_b (
    .clk(clk), .reset(rst_n),
    .req_val(b_req_val), .req_rdy(b_req_rdy),
    .req_msg(b_req_msg), .resp_val(b_resp_val),
    .resp_rdy(b_resp_rdy), .resp_msg(b_resp_msg),
    .spi_cs_n(b_cs_n), .spi_sclk(b_sclk), .spi_mosi(b_mosi),
    .spi_miso(b_mosi), .shreg_load_en(b_ld_en),
    .shreg_load_data(b_ld_data), .shreg_shift_en(b_sh_en),
    .shreg_in(b_sh_in), .shreg_out(b_shreg)
  );

  // external shift registers (the datapath the controller drives)
  always @(posedge clk) begin
    if (ld_en) shreg <= ld_data;
    else if (sh_en) shreg <= {shreg[N-2:0], sh_in};
    if (b_ld_en) b_shreg <= b_ld_data;
    else if (b_sh_en) b_shreg <= {b_shreg[NB-2:0], b_sh_in};
  end

  // slave: loopback, or shifts slv out MSB first on falling SCLK
  logic         loop = 1'b1;
  logic [N-1:0] slv = '0;
  int           nfall = 0;
  logic         sclk_prev = 1'b0;
  logic         slv_bit;
  always @(negedge clk) begin
    if (cs_n) nfall = 0;
    else if (sclk_prev && !sclk) nfall = nfall + 1;
    sclk_prev = sclk;
  end
  always_comb begin
    slv_bit = 1'b0;
    if (nfall < N) slv_bit = slv[N-1-nfall];
  end
  assign miso = loop ? mosi : slv_bit;

  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // timeline model: k = edges since the accepting edge
  bit           m_busy = 0, m_resp = 0;
  int           k = 0, p = 0;
  logic [N-1:0] m_tx = '0, m_rx = '0;
  logic         e_cs, e_sclk, e_rdy, e_rv, e_ld, e_sh;
  int           acc_q[$], hs_q[$];
  logic [N-1:0] rx_q[$];
  int           mon_cs = 0, mon_hi = 0, mon_pulse = 0;
  logic [N-1:0] mon_mosi = '0;
  logic         mon_sp = 1'b0;

  always @(negedge clk) begin : cmp
    if (!rst_n) begin
      chk("rst_cs_n", cs_n, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_resp_val", resp_val, 0);
      chk("rst_load_en", ld_en, 0);
      chk("rst_shift_en", sh_en, 0);
      chk("rst_shreg_in", sh_in, 0);
      m_busy = 0;
      m_resp = 0;
    end else begin
      e_cs = 1; e_sclk = 0; e_rdy = 0;
      e_rv = 0; e_ld = 0; e_sh = 0;
      if (m_busy) begin
        e_cs   = 0;
        p      = (k - 1) / D;
        e_sclk = (p % 2 == 1);
        e_sh   = e_sclk && ((k - 1) % D == D - 1);
        if (e_sclk) chk("mosi", mosi, m_tx[N-1-(p-1)/2]);
      end else if (m_resp) begin
        e_rv = 1;
        chk("resp_msg", resp_msg, m_rx);
      end else begin
        e_rdy = 1;
        e_ld  = req_val;
      end
      chk("cs_n", cs_n, e_cs);
      chk("sclk", sclk, e_sclk);
      chk("req_rdy", req_rdy, e_rdy);
      chk("resp_val", resp_val, e_rv);
      chk("load_en", ld_en, e_ld);
      chk("shift_en", sh_en, e_sh);
      if (ld_en) chk("load_data", ld_data, req_msg);
      if (!cs_n) mon_cs++;
      if (sclk) mon_hi++;
      if (sclk && !mon_sp) begin
        mon_pulse++;
        mon_mosi = {mon_mosi[N-2:0], mosi};
      end
      mon_sp = sclk;
      if (m_busy) begin
        k++;
        if (k > CSLEN) begin
          m_busy = 0;
          m_resp = 1;
        end
      end else if (m_resp) begin
        if (resp_rdy) begin
          m_resp = 0;
          hs_q.push_back(cyc);
          rx_q.push_back(resp_msg);
        end
      end else if (req_val) begin
        m_busy = 1;
        k      = 1;
        m_tx   = req_msg;
        m_rx   = loop ? req_msg : slv;
        acc_q.push_back(cyc);
        mon_cs = 0; mon_hi = 0; mon_pulse = 0;
      end
    end
  end

  // light monitor for the small instance
  int b_cs = 0, b_pulse = 0;
  logic b_sp = 1'b0;
  always @(negedge clk) begin
    if (b_ld_en && b_sh_en) chk("b_ld_and_sh", 1, 0);
    if (b_req_val && b_req_rdy) begin
      b_cs = 0;
      b_pulse = 0;
    end
    if (!b_cs_n) b_cs++;
    if (b_sclk && !b_sp) b_pulse++;
    b_sp = b_sclk;
  end

  task automatic xfer_a(input logic [N-1:0] tx, input int hold,
                        output logic [N-1:0] rx);
    bit got;
    @(posedge clk); #1;
    req_val = 1; req_msg = tx; resp_rdy = 0;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_rdy) begin got = 1; break; end
    end
    chk("accept_timeout", got, 1);
    @(posedge clk); #1;
    req_val = 0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_val) begin got = 1; break; end
    end
    chk("resp_timeout", got, 1);
    repeat (hold) @(posedge clk);
    #1 resp_rdy = 1;
    @(negedge clk);
    rx = resp_msg;
    @(posedge clk); #1;
    resp_rdy = 0;
  endtask

  task automatic xfer_b(input logic [NB-1:0] tx,
                        output logic [NB-1:0] rx);
    bit got;
    @(posedge clk); #1;
    b_req_val = 1; b_req_msg = tx;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_req_rdy) begin got = 1; break; end
    end
    chk("b_accept_timeout", got, 1);
    @(posedge clk); #1;
    b_req_val = 0;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b_resp_val) begin got = 1; break; end
    end
    chk("b_resp_timeout", got, 1);
    rx = b_resp_msg;
    @(posedge clk); #1 b_resp_rdy = 1;
    @(posedge clk); #1 b_resp_rdy = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  logic [N-1:0]  rx, tx;
  logic [NB-1:0] brx, btx;
  int            na, nh, np, hold;
  bit            got;
  logic          pv;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("idle_rdy_after_reset", req_rdy, 1);

    loop = 1;
    xfer_a(8'hA5, 1, rx);
    chk("loop_a5_rx", rx, 8'hA5);
    chk("loop_a5_cs_cycles", mon_cs, 34);
    chk("loop_a5_pulses", mon_pulse, 8);
    chk("loop_a5_hi_cycles", mon_hi, 16);

    loop = 0;
    slv  = 8'h3C;
    xfer_a(8'hC3, 1, rx);
    chk("slave_rx", rx, 8'h3C);
    chk("slave_mosi_bits", mon_mosi, 8'hC3);

    loop = 1;
    xfer_a(8'h66, 10, rx);
    chk("stall_rx", rx, 8'h66);

    // back-to-back requests with resp_rdy held high
    na = acc_q.size();
    nh = hs_q.size();
    @(posedge clk); #1;
    resp_rdy = 1; req_val = 1; req_msg = 8'h01;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (acc_q.size() >= na + 1) begin got = 1; break; end
    end
    #1 req_msg = 8'h80;
    chk("b2b_first_accept", got, 1);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (acc_q.size() >= na + 2) begin got = 1; break; end
    end
    #1 req_val = 0;
    chk("b2b_second_accept", got, 1);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (hs_q.size() >= nh + 2) begin got = 1; break; end
    end
    #1 resp_rdy = 0;
    chk("b2b_resp_done", got, 1);
    if (got) begin
      chk("b2b_gap", acc_q[na+1] - hs_q[nh], 1);
      chk("b2b_rx0", rx_q[nh], 8'h01);
      chk("b2b_rx1", rx_q[nh+1], 8'h80);
    end

    // reset during the 4th HIGH phase
    @(posedge clk); #1;
    req_val = 1; req_msg = 8'hC7;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_rdy) begin got = 1; break; end
    end
    chk("rst_xfer_accept", got, 1);
    @(posedge clk); #1;
    req_val = 0;
    np = 0;
    pv = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (sclk && !pv) np++;
      pv = sclk;
      if (np == 4) break;
    end
    chk("pre_reset_sclk", sclk, 1);
    #1 rst_n = 0;
    #1;
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_resp_val", resp_val, 0);
    chk("abort_req_rdy", req_rdy, 0);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1;
    xfer_a(8'h5A, 1, rx);
    chk("post_reset_rx", rx, 8'h5A);

    for (int t = 0; t < 12; t++) begin
      loop = 1'($urandom % 2);
      slv  = 8'($urandom);
      tx   = 8'($urandom);
      hold = $urandom_range(1, 4);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      xfer_a(tx, hold, rx);
      chk("rand_rx", rx, loop ? tx : slv);
    end
    loop = 1;

    xfer_b(4'h9, brx);
    chk("b_rx_9", brx, 4'h9);
    chk("b_cs_cycles", b_cs, 9);
    chk("b_pulses", b_pulse, 4);
    for (int t = 0; t < 4; t++) begin
      btx = 4'($urandom);
      xfer_b(btx, brx);
      chk("b_rand_rx", brx, btx);
      chk("b_rand_cs", b_cs, 9);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- SPI master transaction controller, mode 0 (CPOL=0, CPHA=0), MSB first, full duplex.
- Sits directly upstream of the SPI datapath shift register and drives its load, shift and serial-in controls.
- Accepts a transmit word on a val/rdy request port and returns the received word on a val/rdy response port.
- Generates spi_cs_n and spi_sclk from the system clock using a programmable divider.

Parameters:
- nbits, 8, transfer word width; must be >= 2.
- clk_div, 2, clk cycles per SCLK half-period; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req_val  input  1  request valid.
- req_rdy  output  1  request ready.
- req_msg  input  nbits  word to transmit.
- resp_val  output  1  response valid.
- resp_rdy  input  1  response ready.
- resp_msg  output  nbits  received word.
- spi_cs_n  output  1  chip select, active-low.
- spi_sclk  output  1  serial clock.
- spi_mosi  output  1  serial data out; equals shreg_out[nbits-1].
- spi_miso  input  1  serial data in.
- shreg_load_en  output  1  shift-register parallel load.
- shreg_load_data  output  nbits  parallel load value; equals req_msg.
- shreg_shift_en  output  1  shift-register shift-left enable.
- shreg_in  output  1  shift-register serial input.
- shreg_out  input  nbits  shift-register contents.

Behaviour:
- States: IDLE, SETUP, HIGH, LOW, HOLD, RESP.
- A divider counter counts 0..clk_div-1 within each timed state (SETUP, HIGH, LOW, HOLD) and clears on every state change.
- A bit counter counts 0..nbits and increments at each HIGH exit.

Outputs:
- spi_cs_n = 0 in SETUP, HIGH, LOW and HOLD; 1 otherwise.
- spi_sclk = 1 only in HIGH.
- req_rdy = 1 only in IDLE.
- resp_val = 1 only in RESP.
- resp_msg = shreg_out.

Reset (reset == 0), immediate and asynchronous:
- State goes to IDLE; all counters and miso_q go to 0.
- spi_cs_n=1, spi_sclk=0, req_rdy=0, resp_val=0, shreg_load_en=0, shreg_shift_en=0, shreg_in=0.
- Reset mid-transfer aborts the transfer; no response is produced.
- After reset release: IDLE with req_rdy=1.

Transitions:
- IDLE: on req_val && req_rdy, drive shreg_load_en=1 combinationally in that cycle and go to SETUP.
- SETUP: after clk_div cycles, go to HIGH. On that edge, register spi_miso into miso_q.
- HIGH: in its last cycle (div == clk_div-1), drive shreg_shift_en=1 and shreg_in=miso_q; increment the bit counter.
  - If this was bit nbits-1, go to HOLD; otherwise go to LOW.
- LOW: after clk_div cycles, go to HIGH and register spi_miso into miso_q on that edge.
- HOLD: after clk_div cycles, go to RESP.
- RESP: hold resp_val=1 and a stable resp_msg until resp_rdy=1, then go to IDLE.

Timing rules:
- MISO is sampled on the SCLK rising edge.
- The shift, and therefore the MOSI change, happens on the SCLK falling edge. MOSI is stable across each rising edge.
- Request handshake at edge 0:
  - spi_cs_n is low for clk_div*(2*nbits+1) cycles.
  - resp_val rises in the next cycle, with no gap to cs_n deassertion.
- shreg_load_en and shreg_shift_en are never both 1.
- clk_div=1 is legal: each state lasts one cycle.
- The next request cannot be accepted until the cycle after the response handshake.

Test Plan:
- Loopback (spi_miso tied to spi_mosi), nbits=8, clk_div=2, req_msg=0xA5 -> spi_cs_n low exactly 34 cycles, 8 SCLK pulses each 2 cycles high, resp_msg=0xA5.
- req_msg=0xC3, slave model drives 0x3C MSB first, changing on falling SCLK -> MOSI bits 1,1,0,0,0,0,1,1 observed at rising edges; resp_msg=0x3C.
- resp_rdy held 0 for 10 cycles after resp_val rises -> resp_val and resp_msg stable, req_rdy=0, spi_cs_n=1, no SCLK toggles; proceeds when resp_rdy=1.
- Back-to-back requests 0x01, 0x80 with resp_rdy=1 -> second request accepted one cycle after the first response handshake; responses in order.
- reset=0 during the 4th HIGH phase -> spi_cs_n=1 and spi_sclk=0 immediately, no resp_val; after release, a new 0x5A loopback transfer returns 0x5A.
- clk_div=1, nbits=4, loopback 0x9 -> spi_cs_n low for 9 cycles, resp_msg=0x9.
